// File: rtl/bel_radix2_sched.sv
// -----------------------------------------------------------------------------
// bel_radix2_sched
//   Stage/group sequencer sitting in front of the radix-2 butterfly engine.
//   For an N = 2^log2n point in-place FFT (data already bit-reversed) it walks
//   the stages m = 1, 2, .., N/2. Each stage has N/(2m) butterfly groups. For
//   every group it issues one start pulse carrying m, the twiddle stride and
//   the group base address. It then waits for the butterfly's finish before
//   it moves on to the next group.
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous reset, active high
//   go_i           start a full transform (only looked at while idle)
//   log2n_i        log2 of the transform length
//   base_adr_i     byte address of element 0
//   busy_o         high from go acceptance until done/err
//   done_o         one-cycle pulse: all stages complete
//   err_o          one-cycle pulse: bad log2n or bus error abort
//   bfly_start_o   one-cycle start pulse to the butterfly
//   bfly_m_o       butterfly half-span m (held stable while a group runs)
//   bfly_fstride_o twiddle stride N/(2m) (held stable while a group runs)
//   bfly_adr_o     group base address (held stable while a group runs)
//   bfly_finish_i  butterfly finished the current group
//   bus_err_i      bus error seen by the butterfly
// -----------------------------------------------------------------------------
module bel_radix2_sched #(
  parameter int AWIDTH    = 32,
  parameter int NUM_WIDTH = 16,
  parameter int ADR_STEP  = 4,
  parameter int MAX_LOG2N = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 go_i,
  input  logic [4:0]           log2n_i,
  input  logic [AWIDTH-1:0]    base_adr_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 bfly_start_o,
  output logic [NUM_WIDTH-1:0] bfly_m_o,
  output logic [NUM_WIDTH-1:0] bfly_fstride_o,
  output logic [AWIDTH-1:0]    bfly_adr_o,
  input  logic                 bfly_finish_i,
  input  logic                 bus_err_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state;
  logic [4:0]            log2n_q;
  logic [4:0]            stage_left;
  logic [AWIDTH-1:0]     base_q;
  logic [NUM_WIDTH-1:0]  grp_left;
  logic [NUM_WIDTH:0]    n_full;
  logic [AWIDTH-1:0]     adr_step;

  // N is formed one bit wider than the counters so that N itself never
  // overflows. Only N/2 is ever stored.
  assign n_full   = (NUM_WIDTH+1)'(1) << log2n_q;
  // Neighbouring groups in a stage are 2*m elements apart. The add wraps
  // modulo 2^AWIDTH.
  assign adr_step = (AWIDTH'(bfly_m_o) << 1) * AWIDTH'(ADR_STEP);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      log2n_q        <= '0;
      stage_left     <= '0;
      base_q         <= '0;
      grp_left       <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      bfly_start_o   <= 1'b0;
      bfly_m_o       <= '0;
      bfly_fstride_o <= '0;
      bfly_adr_o     <= '0;
    end else begin
      bfly_start_o <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go_i) begin
            log2n_q <= log2n_i;
            base_q  <= base_adr_i;
            busy_o  <= 1'b1;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (log2n_q == 5'd0) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= S_DONE;
          end else if (int'(log2n_q) > MAX_LOG2N) begin
            busy_o <= 1'b0;
            err_o  <= 1'b1;
            state  <= S_ERR;
          end else begin
            bfly_m_o       <= NUM_WIDTH'(1);
            bfly_fstride_o <= NUM_WIDTH'(n_full >> 1);
            grp_left       <= NUM_WIDTH'(n_full >> 1);
            bfly_adr_o     <= base_q;
            stage_left     <= log2n_q;
            bfly_start_o   <= 1'b1;
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A bus error wins over a finish that arrives in the same cycle.
          if (bus_err_i) begin
            busy_o <= 1'b0;
            err_o  <= 1'b1;
            state  <= S_ERR;
          end else if (bfly_finish_i) begin
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (grp_left != NUM_WIDTH'(1)) begin
            bfly_adr_o   <= bfly_adr_o + adr_step;
            grp_left     <= grp_left - NUM_WIDTH'(1);
            bfly_start_o <= 1'b1;
            state        <= S_ISSUE;
          end else if (stage_left == 5'd1) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= S_DONE;
          end else begin
            // Next stage: span doubles and the stride halves. The group
            // count equals the new stride.
            bfly_m_o       <= bfly_m_o << 1;
            bfly_fstride_o <= bfly_fstride_o >> 1;
            grp_left       <= bfly_fstride_o >> 1;
            bfly_adr_o     <= base_q;
            stage_left     <= stage_left - 5'd1;
            bfly_start_o   <= 1'b1;
            state          <= S_ISSUE;
          end
        end
        S_DONE, S_ERR: begin
          bfly_m_o       <= '0;
          bfly_fstride_o <= '0;
          bfly_adr_o     <= '0;
          state          <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bel_radix2_sched.sv
module tb_bel_radix2_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        go_i;
  logic [4:0]  log2n_i;
  logic [31:0] base_adr_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        bfly_start_o;
  logic [15:0] bfly_m_o;
  logic [15:0] bfly_fstride_o;
  logic [31:0] bfly_adr_o;
  logic        bfly_finish_i;
  logic        bus_err_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  bel_radix2_sched #(
    .AWIDTH   (32),
    .NUM_WIDTH(16),
    .ADR_STEP (4),
    .MAX_LOG2N(12)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .go_i          (go_i),
    .log2n_i       (log2n_i),
    .base_adr_i    (base_adr_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .bfly_start_o  (bfly_start_o),
    .bfly_m_o      (bfly_m_o),
    .bfly_fstride_o(bfly_fstride_o),
    .bfly_adr_o    (bfly_adr_o),
    .bfly_finish_i (bfly_finish_i),
    .bus_err_i     (bus_err_i)
  );

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One full transform, with the butterfly modelled. fdly is the delay from
  // a start to its finish (>=1). err_grp is the index of the group that
  // reports a bus error along with its finish (-1 for none). With hold_go,
  // go_i stays high the whole time. With skip_go, go_i/log2n_i/base_adr_i
  // are assumed to be already on the inputs.
  task automatic run_case(input int l2n, input logic [31:0] base, input int fdly,
                          input int err_grp, input bit hold_go, input bit skip_go);
    logic [15:0] exp_m[$];
    logic [15:0] exp_fs[$];
    logic [31:0] exp_adr[$];
    int  nn, idx, t, fin_cnt, last_fin, end_t, busy_cyc, exp_starts;
    bit  ended, got_done, got_err, pend_err, setup_err, bus_abort;
    logic [31:0] a;

    setup_err = (l2n > 12);
    if (l2n >= 1 && l2n <= 12) begin
      nn = 1 << l2n;
      for (int m = 1; m < nn; m = m * 2)
        for (int g = 0; g < nn / (2 * m); g++) begin
          a = base + 32'(g * 2 * m * 4);
          exp_m.push_back(16'(m));
          exp_fs.push_back(16'(nn / (2 * m)));
          exp_adr.push_back(a);
        end
    end
    bus_abort  = (err_grp >= 0) && (err_grp < exp_m.size());
    exp_starts = bus_abort ? err_grp + 1 : exp_m.size();

    @(negedge clk_i);
    check_eq("idle_outs", {busy_o, bfly_m_o, bfly_fstride_o, bfly_adr_o}, '0);
    if (!skip_go) begin
      go_i       = 1'b1;
      log2n_i    = 5'(l2n);
      base_adr_i = base;
    end
    idx = 0; t = 0; fin_cnt = -1; last_fin = 0; end_t = 0; busy_cyc = 0;
    ended = 0; got_done = 0; got_err = 0; pend_err = 0;
    while (!ended && t < 5000) begin
      @(negedge clk_i);
      t++;
      if (!hold_go) go_i = 1'b0;
      bfly_finish_i = 1'b0;
      bus_err_i     = 1'b0;
      if (busy_o) busy_cyc++;
      if (fin_cnt > 0) begin
        fin_cnt--;
        if (fin_cnt == 0) begin
          bfly_finish_i = 1'b1;
          bus_err_i     = pend_err;
          last_fin      = t;
          fin_cnt       = -1;
        end
      end
      if (bfly_start_o) begin
        if (idx < exp_m.size()) begin
          check_eq("start_m", bfly_m_o, exp_m[idx]);
          check_eq("start_fstride", bfly_fstride_o, exp_fs[idx]);
          check_eq("start_adr", bfly_adr_o, exp_adr[idx]);
        end else begin
          check_eq("extra_start", idx, exp_m.size());
        end
        check_eq("start_latency", t - last_fin, 2);
        fin_cnt  = fdly;
        pend_err = (idx == err_grp);
        idx++;
      end
      if (done_o) got_done = 1;
      if (err_o)  got_err  = 1;
      if (done_o || err_o) begin
        end_t = t;
        ended = 1;
      end
    end
    bfly_finish_i = 1'b0;
    bus_err_i     = 1'b0;
    check_eq("ended_in_budget", ended, 1);
    check_eq("start_count", idx, exp_starts);
    check_eq("done_pulse", got_done, !(setup_err || bus_abort));
    check_eq("err_pulse", got_err, setup_err || bus_abort);
    check_eq("end_latency", end_t - last_fin, bus_abort ? 1 : 2);
    check_eq("busy_cycles", busy_cyc, end_t - 1);
  endtask

  task automatic idle_stray(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      check_eq("idle_quiet", {bfly_start_o, busy_o, done_o, err_o}, 4'b0000);
      bfly_finish_i = 1'($urandom_range(0, 1));
    end
    @(negedge clk_i);
    check_eq("idle_quiet", {bfly_start_o, busy_o, done_o, err_o}, 4'b0000);
    bfly_finish_i = 1'b0;
  endtask

  task automatic reset_mid_run();
    bit saw;
    @(negedge clk_i);
    go_i = 1'b1; log2n_i = 5'd3; base_adr_i = 32'h200;
    saw = 0;
    for (int i = 0; i < 20 && !saw; i++) begin
      @(negedge clk_i);
      go_i = 1'b0;
      if (bfly_start_o) saw = 1;
    end
    check_eq("rst_reach_start", saw, 1);
    @(negedge clk_i);
    check_eq("rst_pre_busy", busy_o, 1);
    #2 rst_i = 1'b1;
    #1 check_eq("rst_async_outs",
                {busy_o, done_o, err_o, bfly_start_o, bfly_m_o, bfly_fstride_o, bfly_adr_o}, '0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle_stray(3);
  endtask

  initial begin
    int l2n, fd, eg;
    logic [31:0] b;
    rst_i = 1'b1; go_i = 1'b0; log2n_i = '0; base_adr_i = '0;
    bfly_finish_i = 1'b0; bus_err_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_eq("reset_outs",
             {busy_o, done_o, err_o, bfly_start_o, bfly_m_o, bfly_fstride_o, bfly_adr_o}, '0);
    rst_i = 1'b0;

    run_case(3, 32'h100, 3, -1, 0, 0);
    run_case(0, 32'h40, 2, -1, 0, 0);
    run_case(13, 32'h0, 2, -1, 0, 0);
    run_case(4, 32'h1000, 2, 2, 0, 0);
    idle_stray(3);
    run_case(2, 32'h300, 2, -1, 1, 0);
    run_case(2, 32'h300, 1, -1, 0, 1);
    idle_stray(4);
    reset_mid_run();
    run_case(3, 32'h200, 2, -1, 0, 0);
    run_case(3, 32'hFFFF_FFF0, 1, -1, 0, 0);
    run_case(31, 32'h0, 1, -1, 0, 0);

    for (int r = 0; r < 10; r++) begin
      l2n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(13, 31)) : int'($urandom_range(0, 7));
      b   = $urandom;
      fd  = $urandom_range(1, 4);
      eg  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_case(l2n, b, fd, eg, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
